hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Hazard detection and forwarding controller for the 5-stage ARM pipeline.
- Sits beside the ID stage and drives four things:
  - PC load enable.
  - IF/ID load enable and flush.
  - Select of the control-unit NOP mux.
  - Operand-forwarding selects for the three ID-stage operands (Rn, Rm, Rd-as-source).
- Keeps its own shadow pipeline of destination register, rf_en and load flag for the EX, MEM and WB stages.
- Detects load-use and RAW hazards without reading the datapath pipeline registers.

Parameters:
- REG_W, 4, register-index width (16 architectural registers).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- id_rn  input  REG_W  Rn index of the instruction in ID.
- id_rm  input  REG_W  Rm index of the instruction in ID.
- id_rd  input  REG_W  Rd index of the instruction in ID (destination, or store source).
- id_use_rn  input  1  ID instruction reads Rn.
- id_use_rm  input  1  ID instruction reads Rm.
- id_use_rd  input  1  ID instruction reads Rd (store data).
- id_rf_en  input  1  ID instruction writes Rd (control-unit output, pre-mux).
- id_load  input  1  ID instruction is a load.
- id_branch_taken  input  1  branch resolved taken in ID this cycle.
- pc_le  output  1  PC load enable.
- ifid_le  output  1  IF/ID load enable.
- ifid_flush  output  1  clear IF/ID to NOP on next edge.
- cu_mux_s  output  1  NOP-mux select: 0 = zero/NOP control word, 1 = pass CU signals.
- fwd_a  output  2  Rn operand select.
- fwd_b  output  2  Rm operand select.
- fwd_c  output  2  Rd-source operand select.
- stall_cnt  output  CNT_W  total load-use stall cycles since reset.

Behaviour:
- State registers:
  - ex_rd, ex_we, ex_ld
  - mem_rd, mem_we
  - wb_rd, wb_we
  - stall_cnt
- Reset (reset==0 at rising edge):
  - all *_we and ex_ld cleared; all *_rd cleared to 0; stall_cnt cleared to 0.
- Outputs while reset is low (forced):
  - pc_le=1, ifid_le=1, cu_mux_s=0, ifid_flush=0
  - fwd_a=fwd_b=fwd_c=00
  - stall_cnt=0 after the first edge with reset low.
- Reset mid-stall: the stall is abandoned and the shadow pipe is emptied at that edge.
- Shadow pipe advance, every rising edge with reset=1:
  - wb <= mem
  - mem <= ex
  - ex <= {id_rd, id_rf_en & ~stall, id_load & ~stall}
  - A stall therefore inserts a bubble into EX.
- match(x, use): use & (x != 15) & (x equals the rd of the stage being tested, with that stage's we=1). R15 (PC) is never hazarded or forwarded.
- stall (combinational): ex_we & ex_ld & (match(id_rn) | match(id_rm) | match(id_rd)) against ex_rd.
- Outputs when reset=1:
  - pc_le = ~stall
  - ifid_le = ~stall
  - cu_mux_s = ~stall
- Load-use latency: exactly one bubble. On the next cycle the load is in MEM and forwarding uses select 10.
- Forward select encoding:
  - 00 = register file
  - 01 = EX result
  - 10 = MEM result
  - 11 = WB result
- Forward priority: EX > MEM > WB; youngest producer wins.
- While stall=1:
  - fwd_* still computed, but the value is don't-care.
  - The EX match of a load never produces 01.
- Flush: ifid_flush = id_branch_taken & ~stall & reset.
  - Stall plus branch in the same cycle: stall wins, and the branch is re-evaluated next cycle.
- stall_cnt: increments by 1 on each edge where stall=1 and reset=1; saturates at all-ones with no wrap.
- All outputs except stall_cnt are combinational from state and inputs; there is no output latency.

Test Plan:
1. Reset hold: reset=0 for 3 cycles with random inputs -> pc_le=1, ifid_le=1, cu_mux_s=0, fwd_*=00, stall_cnt=0.
2. ALU RAW chain: ADD r1 (id_rd=1, id_rf_en=1), then ID reads id_rn=1 -> fwd_a=01. Next cycle, with an unrelated instruction in between -> fwd_a=10. One cycle later -> fwd_a=11. One cycle after that -> fwd_a=00.
3. Load-use: LDR r2 (id_load=1, id_rd=2), then ID uses id_rm=2 -> exactly 1 cycle with pc_le=ifid_le=cu_mux_s=0. Next cycle fwd_b=10 with no stall; stall_cnt=1.
4. Priority: r3 written by the instructions in both EX and MEM, ID reads id_rd=3 with id_use_rd=1 -> fwd_c=01. R15 producer in EX with an R15 read -> fwd_*=00 and no stall.
5. Branch/stall collision: id_branch_taken=1 while a load-use stall is active -> ifid_flush=0. Next cycle, branch still taken -> ifid_flush=1 for exactly one cycle.
6. Saturation/reset: force 2^CNT_W+3 stall cycles -> stall_cnt holds at all-ones. Assert reset mid-stall -> stall_cnt=0 and the shadow pipe is empty, so the following read of the same reg gives fwd=00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall, branch flush and operand
// forwarding control for the 5-stage ARM pipeline.
module hazard_forward_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_en,
  input  logic             id_load,
  input  logic             id_branch_taken,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_flush,
  output logic             cu_mux_s,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(15);

  logic [REG_W-1:0] r_ex_rd;
  logic [REG_W-1:0] r_mem_rd;
  logic [REG_W-1:0] r_wb_rd;
  logic             r_ex_we;
  logic             r_ex_ld;
  logic             r_mem_we;
  logic             r_wb_we;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  function automatic logic hit(
    input logic [REG_W-1:0] x,
    input logic             u,
    input logic [REG_W-1:0] rd,
    input logic             we
  );
    return u & we & (x != PC_IDX) & (x == rd);
  endfunction

  // A load sitting in EX has no result yet, so it never selects 01.
  function automatic logic [1:0] fsel(
    input logic [REG_W-1:0] x,
    input logic             u,
    input logic [REG_W-1:0] exrd,
    input logic             exwe,
    input logic             exld,
    input logic [REG_W-1:0] memrd,
    input logic             memwe,
    input logic [REG_W-1:0] wbrd,
    input logic             wbwe
  );
    logic [1:0] s;
    s = 2'b00;
    if (hit(x, u, exrd, exwe) && !exld)
      s = 2'b01;
    else if (hit(x, u, memrd, memwe))
      s = 2'b10;
    else if (hit(x, u, wbrd, wbwe))
      s = 2'b11;
    return s;
  endfunction

  assign w_stall = r_ex_we & r_ex_ld &
    (hit(id_rn, id_use_rn, r_ex_rd, r_ex_we) |
     hit(id_rm, id_use_rm, r_ex_rd, r_ex_we) |
     hit(id_rd, id_use_rd, r_ex_rd, r_ex_we));

  always_comb begin
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    cu_mux_s   = 1'b0;
    ifid_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    fwd_c      = 2'b00;
    if (reset) begin
      pc_le      = ~w_stall;
      ifid_le    = ~w_stall;
      cu_mux_s   = ~w_stall;
      ifid_flush = id_branch_taken & ~w_stall;
      fwd_a = fsel(id_rn, id_use_rn, r_ex_rd, r_ex_we, r_ex_ld,
                   r_mem_rd, r_mem_we, r_wb_rd, r_wb_we);
      fwd_b = fsel(id_rm, id_use_rm, r_ex_rd, r_ex_we, r_ex_ld,
                   r_mem_rd, r_mem_we, r_wb_rd, r_wb_we);
      fwd_c = fsel(id_rd, id_use_rd, r_ex_rd, r_ex_we, r_ex_ld,
                   r_mem_rd, r_mem_we, r_wb_rd, r_wb_we);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wb_rd  <= r_mem_rd;
      r_wb_we  <= r_mem_we;
      r_mem_rd <= r_ex_rd;
      r_mem_we <= r_ex_we;
      r_ex_rd  <= id_rd;
      r_ex_we  <= id_rf_en & ~w_stall;
      r_ex_ld  <= id_load & ~w_stall;
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed and random checks of the
// hazard/forwarding controller against a history-based model.
module tb_hazard_forward_unit;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    id_rn, id_rm, id_rd;
  logic          id_use_rn, id_use_rm, id_use_rd;
  logic          id_rf_en, id_load, id_branch_taken;
  logic          pc_le, ifid_le, ifid_flush, cu_mux_s;
  logic [1:0]    fwd_a, fwd_b, fwd_c;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [3:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  // hist[0] is the instruction now in EX, hist[2] the one in WB
  ent_t hist[$];
  int   m_cnt    = 0;
  bit   m_cnt_ok = 1'b0;

  hazard_forward_unit #(.REG_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_use_rd(id_use_rd), .id_rf_en(id_rf_en),
    .id_load(id_load), .id_branch_taken(id_branch_taken),
    .pc_le(pc_le), .ifid_le(ifid_le),
    .ifid_flush(ifid_flush), .cu_mux_s(cu_mux_s),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_match(input logic [3:0] x, input bit u,
                                 input ent_t e);
    return u && e.we && x != 4'd15 && x == e.rd;
  endfunction

  function automatic bit m_stall();
    ent_t e;
    e = hist[0];
    return e.ld && (m_match(id_rn, id_use_rn, e) ||
                    m_match(id_rm, id_use_rm, e) ||
                    m_match(id_rd, id_use_rd, e));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] x,
                                       input bit u);
    for (int i = 0; i < 3; i++) begin
      if (m_match(x, u, hist[i]) && !(i == 0 && hist[i].ld))
        return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  task automatic set_in(input int rn, input int rm, input int rd,
                        input bit urn, input bit urm, input bit urd,
                        input bit we, input bit ld, input bit br);
    id_rn = 4'(rn); id_rm = 4'(rm); id_rd = 4'(rd);
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
    id_rf_en = we; id_load = ld; id_branch_taken = br;
  endtask

  task automatic settle(input string t);
    bit s;
    #1;
    if (!reset) begin
      chk({t, ".pc"}, pc_le, 1);
      chk({t, ".le"}, ifid_le, 1);
      chk({t, ".cu"}, cu_mux_s, 0);
      chk({t, ".fl"}, ifid_flush, 0);
      chk({t, ".fw"}, {fwd_a, fwd_b, fwd_c}, 0);
    end else begin
      s = m_stall();
      chk({t, ".pc"}, pc_le, !s);
      chk({t, ".le"}, ifid_le, !s);
      chk({t, ".cu"}, cu_mux_s, !s);
      chk({t, ".fl"}, ifid_flush, id_branch_taken && !s);
      if (s) begin
        chk({t, ".a01"}, fwd_a == 2'b01, 0);
        chk({t, ".b01"}, fwd_b == 2'b01, 0);
        chk({t, ".c01"}, fwd_c == 2'b01, 0);
      end else begin
        chk({t, ".fa"}, fwd_a, m_fwd(id_rn, id_use_rn));
        chk({t, ".fb"}, fwd_b, m_fwd(id_rm, id_use_rm));
        chk({t, ".fc"}, fwd_c, m_fwd(id_rd, id_use_rd));
      end
    end
    if (m_cnt_ok) chk({t, ".cnt"}, stall_cnt, m_cnt);
  endtask

  task automatic adv();
    bit   s;
    ent_t e;
    s = m_stall();
    @(posedge clk);
    if (!reset) begin
      hist = '{3{ent_t'(0)}};
      m_cnt = 0;
      m_cnt_ok = 1'b1;
    end else begin
      e.rd = id_rd;
      e.we = id_rf_en && !s;
      e.ld = id_load && !s;
      hist.push_front(e);
      void'(hist.pop_back());
      if (s && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 15 : r;
  endfunction

  task automatic rnd_in();
    set_in(pick(), pick(), pick(), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
  endtask

  initial begin
    hist = '{3{ent_t'(0)}};
    @(negedge clk);

    // reset hold
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      settle("t1");
      chk("t1.pc1", pc_le, 1);
      chk("t1.cu0", cu_mux_s, 0);
      chk("t1.fwd0", {fwd_a, fwd_b, fwd_c}, 0);
      if (i > 0) chk("t1.cnt0", stall_cnt, 0);
      adv();
    end
    reset = 1'b1;

    // ALU RAW chain on r1
    set_in(0, 0, 1, 0, 0, 0, 1, 0, 0); settle("t2"); adv();
    set_in(1, 0, 5, 1, 0, 0, 0, 0, 0); settle("t2");
    chk("t2.ex", fwd_a, 2'b01); adv();
    settle("t2"); chk("t2.mem", fwd_a, 2'b10); adv();
    settle("t2"); chk("t2.wb", fwd_a, 2'b11); adv();
    settle("t2"); chk("t2.rf", fwd_a, 2'b00); adv();

    // load-use on r2
    set_in(0, 0, 2, 0, 0, 0, 1, 1, 0); settle("t3"); adv();
    set_in(0, 2, 7, 0, 1, 0, 0, 0, 0); settle("t3");
    chk("t3.stall", {pc_le, ifid_le, cu_mux_s}, 3'b000); adv();
    settle("t3");
    chk("t3.go", {pc_le, ifid_le, cu_mux_s}, 3'b111);
    chk("t3.fb", fwd_b, 2'b10);
    chk("t3.cnt", stall_cnt, 1); adv();

    // priority and R15
    set_in(0, 0, 3, 0, 0, 0, 1, 0, 0); settle("t4"); adv();
    set_in(0, 0, 3, 0, 0, 0, 1, 0, 0); settle("t4"); adv();
    set_in(0, 0, 3, 0, 0, 1, 0, 0, 0); settle("t4");
    chk("t4.prio", fwd_c, 2'b01); adv();
    set_in(0, 0, 15, 0, 0, 0, 1, 1, 0); settle("t4"); adv();
    set_in(15, 15, 15, 1, 1, 1, 0, 0, 0); settle("t4");
    chk("t4.r15f", {fwd_a, fwd_b, fwd_c}, 0);
    chk("t4.r15s", pc_le, 1); adv();

    // branch during stall
    set_in(0, 0, 4, 0, 0, 0, 1, 1, 0); settle("t5"); adv();
    set_in(4, 0, 8, 1, 0, 0, 0, 0, 1); settle("t5");
    chk("t5.fl0", ifid_flush, 0);
    chk("t5.st", pc_le, 0); adv();
    settle("t5"); chk("t5.fl1", ifid_flush, 1); adv();
    set_in(4, 0, 8, 1, 0, 0, 0, 0, 0); settle("t5");
    chk("t5.fl2", ifid_flush, 0); adv();

    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      rnd_in();
      reset = ($urandom_range(0, 49) != 0);
      settle("rnd");
      adv();
    end
    reset = 1'b1;

    // saturation, then reset mid-stall
    for (int i = 0; i < CMAX + 4; i++) begin
      set_in(0, 0, 6, 0, 0, 0, 1, 1, 0); settle("t6"); adv();
      set_in(6, 0, 9, 1, 0, 0, 0, 0, 0); settle("t6"); adv();
    end
    chk("t6.sat", stall_cnt, CMAX);
    set_in(0, 0, 6, 0, 0, 0, 1, 1, 0); settle("t6"); adv();
    set_in(6, 0, 9, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    settle("t6r");
    chk("t6.rpc", pc_le, 1); adv();
    reset = 1'b1;
    settle("t6");
    chk("t6.cnt0", stall_cnt, 0);
    chk("t6.fa", fwd_a, 2'b00);
    chk("t6.pc", pc_le, 1); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
